// File: rtl/ram_delay_ctrl.sv
// Delay-length / flush sequencer for the RAM delay line.
// Takes range-checked delay requests, flushes the line and waits for it to report valid.
module ram_delay_ctrl #(
   parameter int P_NBITS_ADDR = 8,
   parameter int P_N_DEFAULT  = 16,
   parameter int P_N_MIN      = 2,
   parameter int P_NBITS_TMO  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_req,
   input  logic [P_NBITS_ADDR-1:0] cfg_n,
   output logic                    cfg_ack,
   output logic                    cfg_err,
   input  logic                    wr_in,
   output logic [P_NBITS_ADDR-1:0] dl_n,
   output logic                    dl_flush,
   output logic                    dl_wr,
   input  logic                    dl_valid,
   output logic                    ready,
   output logic                    busy,
   output logic                    err_sticky
);

   // state   | meaning
   // S_RUN   | line settled; requests accepted and range-checked here
   // S_APPLY | load the new delay length, start the flush
   // S_FLUSH | flush asserted, counting write strobes until dl_n+2
   // S_WAIT  | flush released, waiting for dl_valid or timeout
   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_APPLY = 2'd1,
      S_FLUSH = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   localparam logic [P_NBITS_ADDR-1:0] LP_N_DEFAULT = P_NBITS_ADDR'(P_N_DEFAULT);
   localparam logic [P_NBITS_ADDR-1:0] LP_N_MIN     = P_NBITS_ADDR'(P_N_MIN);
   localparam logic [P_NBITS_ADDR:0]   LP_FCNT_ONE  = (P_NBITS_ADDR+1)'(1);
   localparam logic [P_NBITS_ADDR:0]   LP_FCNT_TWO  = (P_NBITS_ADDR+1)'(2);
   localparam logic [P_NBITS_TMO-1:0]  LP_TMO_ONE   = P_NBITS_TMO'(1);
   localparam logic [P_NBITS_TMO-1:0]  LP_TMO_MAX   = '1;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [P_NBITS_ADDR-1:0] r_n_req;
   logic [P_NBITS_ADDR-1:0] r_dl_n;
   logic [P_NBITS_ADDR:0]   r_flush_cnt;
   logic [P_NBITS_ADDR:0]   w_flush_inc;
   logic [P_NBITS_ADDR:0]   w_flush_tgt;
   logic [P_NBITS_TMO-1:0]  r_tmo_cnt;
   logic [P_NBITS_TMO-1:0]  w_tmo_inc;
   logic                    r_pend;
   logic                    r_owner;
   logic                    r_ack;
   logic                    r_err;
   logic                    r_flush;
   logic                    r_ready;
   logic                    r_busy;
   logic                    r_sticky;
   logic                    w_accept;
   logic                    w_ack;
   logic                    w_ack_err;
   logic                    w_flush_done;
   logic                    w_tmo_done;

   // Exit fires on the strobe that brings the count to dl_n+2, so the line sees exactly dl_n+2 flushed writes.
   assign w_flush_inc  = r_flush_cnt + LP_FCNT_ONE;
   assign w_flush_tgt  = {1'b0, r_dl_n} + LP_FCNT_TWO;
   assign w_flush_done = wr_in && (w_flush_inc == w_flush_tgt);
   assign w_tmo_inc    = r_tmo_cnt + LP_TMO_ONE;
   assign w_tmo_done   = (w_tmo_inc == LP_TMO_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FLUSH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_ack       = 1'b0;
      w_ack_err   = 1'b0;
      case (r_state)
         S_RUN: begin
            if (r_pend) begin
               if (r_n_req < LP_N_MIN) begin
                  w_ack     = 1'b1;
                  w_ack_err = 1'b1;
               end else if (r_n_req == r_dl_n) begin
                  w_ack = 1'b1;
               end else begin
                  w_state_nxt = S_APPLY;
               end
            end else if (cfg_req && !r_ack) begin
               w_accept = 1'b1;
            end
         end
         S_APPLY: begin
            w_state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            if (w_flush_done) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            // Only a sequence started by a request owes an ack; the post-reset one does not.
            if (dl_valid) begin
               w_state_nxt = S_RUN;
               w_ack       = r_owner;
            end else if (w_tmo_done) begin
               w_state_nxt = S_RUN;
               w_ack       = r_owner;
               w_ack_err   = r_owner;
            end
         end
         default: begin
            w_state_nxt = S_FLUSH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_n_req     <= '0;
         r_dl_n      <= LP_N_DEFAULT;
         r_flush_cnt <= '0;
         r_tmo_cnt   <= '0;
         r_pend      <= 1'b0;
         r_owner     <= 1'b0;
         r_ack       <= 1'b0;
         r_err       <= 1'b0;
         r_flush     <= 1'b1;
         r_ready     <= 1'b0;
         r_busy      <= 1'b1;
         r_sticky    <= 1'b0;
      end else begin
         r_ack   <= w_ack;
         r_err   <= w_ack_err;
         r_pend  <= w_accept;
         r_flush <= (w_state_nxt == S_FLUSH);
         r_busy  <= (w_state_nxt != S_RUN);
         r_ready <= (w_state_nxt == S_RUN) && dl_valid;
         if (w_ack) begin
            r_sticky <= w_ack_err;
         end
         if (w_accept) begin
            r_n_req <= cfg_n;
         end
         if ((r_state == S_RUN) && (w_state_nxt == S_APPLY)) begin
            r_owner <= 1'b1;
         end else if ((r_state == S_WAIT) && (w_state_nxt == S_RUN)) begin
            r_owner <= 1'b0;
         end
         if (r_state == S_APPLY) begin
            r_dl_n      <= r_n_req;
            r_flush_cnt <= '0;
         end else if ((r_state == S_FLUSH) && wr_in) begin
            r_flush_cnt <= w_flush_inc;
         end
         if ((r_state == S_FLUSH) && w_flush_done) begin
            r_tmo_cnt <= '0;
         end else if (r_state == S_WAIT) begin
            r_tmo_cnt <= w_tmo_inc;
         end
      end
   end

   assign cfg_ack    = r_ack;
   assign cfg_err    = r_err;
   assign dl_n       = r_dl_n;
   assign dl_flush   = r_flush;
   assign dl_wr      = wr_in;
   assign ready      = r_ready;
   assign busy       = r_busy;
   assign err_sticky = r_sticky;

endmodule

// File: tb/tb_ram_delay_ctrl.sv
// Self-checking bench for ram_delay_ctrl: per-cycle vector table for the handshake
// plus directed multi-cycle sequences for flush, timeout, reset and duty-cycle cases.
`timescale 1ns/1ps
module tb_ram_delay_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_req;
   logic [7:0] cfg_n;
   logic       cfg_ack;
   logic       cfg_err;
   logic       wr_in;
   logic [7:0] dl_n;
   logic       dl_flush;
   logic       dl_wr;
   logic       dl_valid;
   logic       ready;
   logic       busy;
   logic       err_sticky;

   always #5 clk = ~clk;

   ram_delay_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_req    (cfg_req),
      .cfg_n      (cfg_n),
      .cfg_ack    (cfg_ack),
      .cfg_err    (cfg_err),
      .wr_in      (wr_in),
      .dl_n       (dl_n),
      .dl_flush   (dl_flush),
      .dl_wr      (dl_wr),
      .dl_valid   (dl_valid),
      .ready      (ready),
      .busy       (busy),
      .err_sticky (err_sticky)
   );

   // Delay-line stand-in: valid three cycles after flush drops, unless held low.
   logic       stub_low = 1'b0;
   logic [1:0] vcnt = 2'd0;
   always @(posedge clk) begin
      if (dl_flush || stub_low) vcnt <= 2'd0;
      else if (vcnt != 2'd3)    vcnt <= vcnt + 2'd1;
   end
   assign dl_valid = !stub_low && !dl_flush && (vcnt == 2'd3);

   int n_total = 0;
   int n_pass  = 0;
   int wr_period = 1;
   int phase = 0;
   bit wr_auto = 1'b1;
   bit ack_last = 1'b0;

   typedef struct {
      logic       req;
      logic [7:0] n;
      logic       wr;
      logic       ack;
      logic       err;
      logic       sticky;
      logic       busy;
      logic       flush;
      logic       ready;
      logic [7:0] dln;
   } vec_t;
   vec_t vecs [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      else             n_pass++;
   endtask

   // One clock; outputs are sampled and the next inputs driven 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (ack_last) cfg_req = 1'b0;
      ack_last = cfg_ack;
      if (wr_auto) begin
         wr_in = (wr_period > 0) && ((phase % wr_period) == 0);
         phase++;
      end
   endtask

   task automatic run_flow(input int budget, output int strobes, output int waits, output int fcyc,
                           output int acks, output int err_at_ack, output int bad_ready, output int expired);
      bit seen_busy;
      bit seen_flush;
      strobes = 0; waits = 0; fcyc = 0; acks = 0; err_at_ack = 0; bad_ready = 0; expired = 1;
      seen_busy  = busy;
      seen_flush = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (dl_flush) begin
            seen_flush = 1'b1;
            fcyc++;
            if (wr_in) strobes++;
         end else if (busy && seen_flush) begin
            waits++;
         end
         tick();
         if (cfg_ack) begin
            acks++;
            err_at_ack = cfg_err;
         end
         if (busy) seen_busy = 1'b1;
         if (busy && ready) bad_ready++;
         if (seen_busy && !busy) begin
            expired = 0;
            break;
         end
      end
   endtask

   int st, wt, fc, ak, ea, br, ex;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; cfg_req = 1'b0; cfg_n = 8'd0; wr_in = 1'b0;

      // Reset values
      tick();
      chk("rst_dl_n", dl_n, 16);
      chk("rst_flush", dl_flush, 1);
      chk("rst_ack", cfg_ack, 0);
      chk("rst_err", cfg_err, 0);
      chk("rst_ready", ready, 0);
      chk("rst_busy", busy, 1);
      chk("rst_sticky", err_sticky, 0);
      tick();
      rst = 1'b0;

      // Post-reset flush: 18 strobes, no ack
      run_flow(200, st, wt, fc, ak, ea, br, ex);
      chk("boot_done", ex, 0);
      chk("boot_strobes", st, 18);
      chk("boot_wait_cycles", wt, 4);
      chk("boot_acks", ak, 0);
      chk("boot_ready", ready, 1);
      chk("boot_busy", busy, 0);
      chk("boot_dl_n", dl_n, 16);

      // Handshake vectors: illegal n=1, then n=16 equal to current (cfg_n changes after acceptance)
      vecs[0] = '{1'b1, 8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd16};
      vecs[1] = '{1'b1, 8'd1,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd16};
      vecs[2] = '{1'b1, 8'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd16};
      vecs[3] = '{1'b0, 8'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd16};
      vecs[4] = '{1'b1, 8'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd16};
      vecs[5] = '{1'b1, 8'd99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd16};
      vecs[6] = '{1'b1, 8'd99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd16};
      vecs[7] = '{1'b0, 8'd99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd16};
      vecs[8] = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd16};
      wr_auto = 1'b0;
      for (int i = 0; i < 9; i++) begin
         cfg_req = vecs[i].req;
         cfg_n   = vecs[i].n;
         wr_in   = vecs[i].wr;
         tick();
         chk($sformatf("vec%0d_ack", i),    cfg_ack,    vecs[i].ack);
         chk($sformatf("vec%0d_err", i),    cfg_err,    vecs[i].err);
         chk($sformatf("vec%0d_sticky", i), err_sticky, vecs[i].sticky);
         chk($sformatf("vec%0d_busy", i),   busy,       vecs[i].busy);
         chk($sformatf("vec%0d_flush", i),  dl_flush,   vecs[i].flush);
         chk($sformatf("vec%0d_ready", i),  ready,      vecs[i].ready);
         chk($sformatf("vec%0d_dl_n", i),   dl_n,       vecs[i].dln);
         chk($sformatf("vec%0d_dl_wr", i),  dl_wr,      vecs[i].wr);
      end
      wr_auto = 1'b1;
      wr_period = 1;

      // dl_valid gap in S_RUN: ready follows with one cycle of latency
      stub_low = 1'b1;
      tick();
      chk("gap_ready_low", ready, 0);
      chk("gap_busy", busy, 0);
      stub_low = 1'b0;
      repeat (3) tick();
      chk("gap_ready_still_low", ready, 0);
      tick();
      chk("gap_ready_back", ready, 1);

      // Reconfigure to 40
      cfg_req = 1'b1; cfg_n = 8'd40;
      run_flow(400, st, wt, fc, ak, ea, br, ex);
      chk("n40_done", ex, 0);
      chk("n40_strobes", st, 42);
      chk("n40_wait_cycles", wt, 4);
      chk("n40_acks", ak, 1);
      chk("n40_err", ea, 0);
      chk("n40_ready_while_busy", br, 0);
      chk("n40_dl_n", dl_n, 40);
      chk("n40_ready", ready, 1);
      tick();
      chk("n40_ack_pulse", cfg_ack, 0);
      tick();
      chk("n40_no_reaccept", busy, 0);

      // Boundaries: smallest legal length and full-range length (flush count past 8 bits)
      cfg_req = 1'b1; cfg_n = 8'd2;
      run_flow(400, st, wt, fc, ak, ea, br, ex);
      chk("n2_done", ex, 0);
      chk("n2_strobes", st, 4);
      chk("n2_err", ea, 0);
      chk("n2_dl_n", dl_n, 2);
      repeat (2) tick();
      cfg_req = 1'b1; cfg_n = 8'd255;
      run_flow(800, st, wt, fc, ak, ea, br, ex);
      chk("n255_done", ex, 0);
      chk("n255_strobes", st, 257);
      chk("n255_acks", ak, 1);
      chk("n255_dl_n", dl_n, 255);
      repeat (2) tick();

      // Timeout: valid never rises
      stub_low = 1'b1;
      cfg_req = 1'b1; cfg_n = 8'd20;
      run_flow(70000, st, wt, fc, ak, ea, br, ex);
      chk("tmo_done", ex, 0);
      chk("tmo_strobes", st, 22);
      chk("tmo_wait_cycles", wt, 65535);
      chk("tmo_acks", ak, 1);
      chk("tmo_err", ea, 1);
      chk("tmo_sticky", err_sticky, 1);
      chk("tmo_ready", ready, 0);
      chk("tmo_dl_n", dl_n, 20);
      stub_low = 1'b0;
      repeat (4) tick();
      chk("tmo_ready_recovers", ready, 1);
      chk("tmo_sticky_holds", err_sticky, 1);

      // Reset in the middle of a flush for n=50
      cfg_req = 1'b1; cfg_n = 8'd50;
      ex = 1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (dl_flush && (dl_n == 8'd50)) begin
            ex = 0;
            break;
         end
      end
      chk("n50_reached_flush", ex, 0);
      repeat (10) tick();
      rst = 1'b1;
      cfg_n = 8'd12;
      tick();
      rst = 1'b0;
      chk("midrst_dl_n", dl_n, 16);
      chk("midrst_flush", dl_flush, 1);
      chk("midrst_busy", busy, 1);
      chk("midrst_ack", cfg_ack, 0);
      chk("midrst_sticky", err_sticky, 0);
      run_flow(200, st, wt, fc, ak, ea, br, ex);
      chk("midrst_done", ex, 0);
      chk("midrst_strobes", st, 18);
      chk("midrst_acks", ak, 0);

      // Request held through the reset flush is taken on return to S_RUN
      run_flow(400, st, wt, fc, ak, ea, br, ex);
      chk("held_done", ex, 0);
      chk("held_strobes", st, 14);
      chk("held_acks", ak, 1);
      chk("held_err", ea, 0);
      chk("held_dl_n", dl_n, 12);
      repeat (2) tick();

      // 1-in-4 write duty during the flush of n=10
      wr_period = 4;
      cfg_req = 1'b1; cfg_n = 8'd10;
      run_flow(400, st, wt, fc, ak, ea, br, ex);
      chk("duty_done", ex, 0);
      chk("duty_strobes", st, 12);
      chk("duty_flush_cycles_in_range", (fc >= 45) && (fc <= 48), 1);
      chk("duty_acks", ak, 1);
      chk("duty_dl_n", dl_n, 10);
      wr_period = 1;
      repeat (2) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
